// File: rtl/console_pkg.sv
// console_pkg: shared constants and types for the console cursor controller.
// Holds default screen geometry, the control-code bytes the controller
// recognises, the blank cell value written by clear/backspace, and the
// controller state encoding.
package console_pkg;

  localparam int NUM_ROWS_DEF = 3;
  localparam int NUM_COLS_DEF = 10;

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_FF = 8'h0C;

  // Blank cell: color 0, ASCII space
  localparam logic [8:0] SPACE_CELL = 9'h020;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCROLL = 2'd1,
    CLEAR  = 2'd2
  } state_t;

endpackage

// File: rtl/console_cursor_ctrl.sv
// console_cursor_ctrl: turns a byte stream into writes to a character-cell
// text buffer, tracking the cursor and handling LF/CR/BS/FF.
// Build option: define CONSOLE_SCROLL_EN to scroll the screen up one row when
// a newline happens on the last row; otherwise the cursor wraps to (0,0) and
// row 0 is cleared.
// Handshake: a byte transfers on a clock edge where in_valid && in_ready;
// in_ready is high exactly when the controller is IDLE, independent of in_valid.
module console_cursor_ctrl
  import console_pkg::*;
#(
  parameter int NUM_ROWS = NUM_ROWS_DEF,
  parameter int NUM_COLS = NUM_COLS_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic [1:0] in_color,
  output logic       in_ready,
  output logic       buf_we,
  output logic [4:0] buf_waddr,
  output logic [8:0] buf_wdata,
  output logic [4:0] buf_raddr,
  input  logic [8:0] buf_rdata,
  output logic [3:0] cursor_x,
  output logic [1:0] cursor_y,
  output logic       busy
);

  localparam logic [3:0] LAST_COL  = 4'(NUM_COLS - 1);
  localparam logic [1:0] LAST_ROW  = 2'(NUM_ROWS - 1);
  localparam logic [4:0] LAST_CELL = 5'(NUM_ROWS * NUM_COLS - 1);
`ifdef CONSOLE_SCROLL_EN
  localparam logic [4:0] ROW_STEP       = 5'(NUM_COLS);
  localparam logic [4:0] SCROLL_LAST    = 5'((NUM_ROWS - 1) * NUM_COLS - 1);
  localparam logic [4:0] LAST_ROW_START = 5'((NUM_ROWS - 1) * NUM_COLS);
`else
  localparam logic [4:0] ROW0_END = 5'(NUM_COLS - 1);
  // Buffer read-back only matters when scrolling
  logic unused_rdata;
  assign unused_rdata = ^buf_rdata;
`endif

  state_t     state_q, state_d;
  logic [3:0] x_q, x_d;
  logic [1:0] y_q, y_d;
  logic [4:0] k_q, k_d;      // cell index being scrolled/cleared
  logic [4:0] end_q, end_d;  // last cell of the current clear range

  // y*NUM_COLS + x as a sum of shifted rows, one term per set bit of NUM_COLS
  function automatic logic [4:0] cell_idx(input logic [1:0] y, input logic [3:0] x);
    logic [4:0] acc;
    acc = {1'b0, x};
    for (int b = 0; b < 5; b++) begin
      if (((NUM_COLS >> b) & 1) == 1) acc = acc + 5'({3'b000, y} << b);
    end
    return acc;
  endfunction

  // State, cursor and sweep registers; reset aborts any sweep in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= 4'd0;
      y_q     <= 2'd0;
      k_q     <= 5'd0;
      end_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      k_q     <= k_d;
      end_q   <= end_d;
    end
  end

  // Byte decode, cursor update, sweep sequencing and buffer write port
  always_comb begin
    logic do_nl;
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    k_d       = k_q;
    end_d     = end_q;
    buf_we    = 1'b0;
    buf_waddr = cell_idx(y_q, x_q);
    buf_wdata = SPACE_CELL;
    buf_raddr = 5'd0;
    do_nl     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_data >= 8'h20 && in_data <= 8'h7E) begin
            buf_we    = 1'b1;
            buf_wdata = {in_color, in_data[6:0]};
            if (x_q == LAST_COL) do_nl = 1'b1;
            else x_d = x_q + 4'd1;
          end else if (in_data == CH_LF) begin
            do_nl = 1'b1;
          end else if (in_data == CH_CR) begin
            x_d = 4'd0;
          end else if (in_data == CH_BS) begin
            if (x_q != 4'd0) begin
              x_d       = x_q - 4'd1;
              buf_we    = 1'b1;
              buf_waddr = cell_idx(y_q, x_q - 4'd1);
            end
          end else if (in_data == CH_FF) begin
            x_d     = 4'd0;
            y_d     = 2'd0;
            k_d     = 5'd0;
            end_d   = LAST_CELL;
            state_d = CLEAR;
          end
          if (do_nl) begin
            x_d = 4'd0;
            if (y_q < LAST_ROW) begin
              y_d = y_q + 2'd1;
            end else begin
`ifdef CONSOLE_SCROLL_EN
              k_d     = 5'd0;
              state_d = SCROLL;
`else
              y_d     = 2'd0;
              k_d     = 5'd0;
              end_d   = ROW0_END;
              state_d = CLEAR;
`endif
            end
          end
        end
      end
`ifdef CONSOLE_SCROLL_EN
      SCROLL: begin
        buf_raddr = k_q + ROW_STEP;
        buf_we    = 1'b1;
        buf_waddr = k_q;
        buf_wdata = buf_rdata;
        if (k_q == SCROLL_LAST) begin
          k_d     = LAST_ROW_START;
          end_d   = LAST_CELL;
          state_d = CLEAR;
        end else begin
          k_d = k_q + 5'd1;
        end
      end
`endif
      CLEAR: begin
        buf_we    = 1'b1;
        buf_waddr = k_q;
        buf_wdata = SPACE_CELL;
        if (k_q == end_q) state_d = IDLE;
        else k_d = k_q + 5'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign cursor_x = x_q;
  assign cursor_y = y_q;

endmodule
